// File: rtl/vscale_lsu_pkg.sv
// Shared types and helpers for the vscale load/store unit.
//   lsu_mem_type_t : access type encoding; low two bits are log2(size) for
//                    loads and stores, bit 2 selects zero extension on loads
//   EXC_*          : exception cause codes reported on exc_code
//   lsu_entry_t    : per-access control bits kept while an access is in flight
//   size_mask      : byte-enable pattern for an access size before lane shift
//   align_check    : 1 when the byte offset is not a multiple of the size
package vscale_lsu_pkg;

  typedef enum logic [2:0] {
    LB  = 3'd0,
    LH  = 3'd1,
    LW  = 3'd2,
    LD  = 3'd3,
    LBU = 3'd4,
    LHU = 3'd5,
    LWU = 3'd6
  } lsu_mem_type_t;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_FAULT    = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_FAULT    = 4'd7;

  typedef struct packed {
    logic          wen;
    lsu_mem_type_t mtype;
  } lsu_entry_t;

  function automatic logic [7:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 8'h01;
      2'd1:    return 8'h03;
      2'd2:    return 8'h0f;
      default: return 8'hff;
    endcase
  endfunction

  function automatic logic align_check(input logic [1:0] size, input logic [2:0] off);
    case (size)
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      2'd3:    return |off;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vscale_lsu_fifo.sv
// In-order queue of outstanding memory accesses.
//   clk_i, rst_ni          : clock, async active-low reset
//   push_i, push_*_i       : enqueue one access (control bits, byte address, rd tag)
//   pop_i                  : dequeue head (caller guarantees non-empty)
//   flush_i                : mark every stored entry as dropped
//   head_*_o               : head entry contents and its drop flag
//   full_o, empty_o        : occupancy status
module vscale_lsu_fifo
  import vscale_lsu_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32,
  parameter int unsigned RW    = 5
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  lsu_entry_t    push_entry_i,
  input  logic [AW-1:0] push_addr_i,
  input  logic [RW-1:0] push_rd_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output lsu_entry_t    head_entry_o,
  output logic [AW-1:0] head_addr_o,
  output logic [RW-1:0] head_rd_o,
  output logic          head_drop_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  lsu_entry_t    entry_q [DEPTH];
  logic [AW-1:0] addr_q  [DEPTH];
  logic [RW-1:0] rd_q    [DEPTH];
  logic [DEPTH-1:0] drop_q, drop_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = push_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_i  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push_i && !pop_i) count_d = count_q + 1'b1;
    if (!push_i && pop_i) count_d = count_q - 1'b1;
    // Flush marks every slot; a slot is un-marked only when reused by a push.
    drop_d = drop_q;
    if (flush_i) drop_d = '1;
    if (push_i)  drop_d[wr_ptr_q] = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      entry_q[wr_ptr_q] <= push_entry_i;
      addr_q[wr_ptr_q]  <= push_addr_i;
      rd_q[wr_ptr_q]    <= push_rd_i;
    end
  end

  assign head_entry_o = entry_q[rd_ptr_q];
  assign head_addr_o  = addr_q[rd_ptr_q];
  assign head_rd_o    = rd_q[rd_ptr_q];
  assign head_drop_o  = drop_q[rd_ptr_q];
  assign full_o       = (count_q == FULL_CNT);
  assign empty_o      = (count_q == '0);

endmodule

// File: rtl/vscale_lsu.sv
// Load/store unit between execute and the data-memory port.
//   req_*       : access request from execute (valid/ready handshake)
//   flush       : drop all in-flight accesses
//   dmem_req_*  : word-aligned memory request with byte strobes and lane-shifted data
//   dmem_resp_* : in-order memory responses, optional access fault
//   resp_*      : registered one-cycle completion with extended load data
//   exc_*       : exception cause and faulting byte address for the completion
//   proto_err   : sticky flag for a response with nothing outstanding
module vscale_lsu
  import vscale_lsu_pkg::*;
#(
  parameter int unsigned XPR_LEN  = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RD_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_wen,
  input  logic [2:0]             req_type,
  input  logic [XPR_LEN-1:0]     req_addr,
  input  logic [XPR_LEN-1:0]     req_wdata,
  input  logic [RD_WIDTH-1:0]    req_rd,
  input  logic                   flush,
  output logic                   dmem_req_valid,
  input  logic                   dmem_req_ready,
  output logic [XPR_LEN-1:0]     dmem_addr,
  output logic                   dmem_wen,
  output logic [XPR_LEN/8-1:0]   dmem_wstrb,
  output logic [XPR_LEN-1:0]     dmem_wdata,
  input  logic                   dmem_resp_valid,
  input  logic [XPR_LEN-1:0]     dmem_rdata,
  input  logic                   dmem_resp_err,
  output logic                   resp_valid,
  output logic                   resp_wen,
  output logic [RD_WIDTH-1:0]    resp_rd,
  output logic [XPR_LEN-1:0]     resp_data,
  output logic                   exc_valid,
  output logic [3:0]             exc_code,
  output logic [XPR_LEN-1:0]     exc_addr,
  output logic                   proto_err
);

  localparam int unsigned STRB_W = XPR_LEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);

  lsu_entry_t           head_entry;
  logic [XPR_LEN-1:0]   head_addr;
  logic [RD_WIDTH-1:0]  head_rd;
  logic                 head_drop, fifo_full, fifo_empty;
  logic [1:0]           req_size;
  logic [OFF_W-1:0]     req_off, head_off;
  logic                 req_misaligned, accept_mem, accept_local, resp_hit, resp_stray;
  logic [XPR_LEN-1:0]   ld_shift, ld_ext;

  logic                 resp_valid_q, resp_valid_d, resp_wen_q, resp_wen_d;
  logic [RD_WIDTH-1:0]  resp_rd_q, resp_rd_d;
  logic [XPR_LEN-1:0]   resp_data_q, resp_data_d, exc_addr_q, exc_addr_d;
  logic                 exc_valid_q, exc_valid_d, proto_err_q, proto_err_d;
  logic [3:0]           exc_code_q, exc_code_d;

  assign req_size       = req_type[1:0];
  assign req_off        = req_addr[OFF_W-1:0];
  assign req_misaligned = align_check(req_size, req_addr[2:0]);

  // Misaligned accesses never reach memory, so they wait only for an empty queue.
  assign req_ready      = reset_n && !fifo_full && !flush &&
                          (req_misaligned ? fifo_empty : dmem_req_ready);
  assign dmem_req_valid = reset_n && req_valid && !req_misaligned && !fifo_full && !flush;
  assign accept_mem     = dmem_req_valid && dmem_req_ready;
  assign accept_local   = req_valid && req_ready && req_misaligned;

  assign dmem_addr  = dmem_req_valid ? {req_addr[XPR_LEN-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign dmem_wen   = dmem_req_valid && req_wen;
  assign dmem_wstrb = dmem_wen ? (STRB_W'(size_mask(req_size)) << req_off) : '0;
  assign dmem_wdata = dmem_wen ? (req_wdata << {req_off, 3'b000}) : '0;

  assign resp_hit   = dmem_resp_valid && !fifo_empty;
  assign resp_stray = dmem_resp_valid && fifo_empty;

  vscale_lsu_fifo #(
    .DEPTH (DEPTH),
    .AW    (XPR_LEN),
    .RW    (RD_WIDTH)
  ) u_fifo (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .push_i       (accept_mem),
    .push_entry_i ('{wen: req_wen, mtype: lsu_mem_type_t'(req_type)}),
    .push_addr_i  (req_addr),
    .push_rd_i    (req_rd),
    .pop_i        (resp_hit),
    .flush_i      (flush),
    .head_entry_o (head_entry),
    .head_addr_o  (head_addr),
    .head_rd_o    (head_rd),
    .head_drop_o  (head_drop),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty)
  );

  assign head_off = head_addr[OFF_W-1:0];
  assign ld_shift = dmem_rdata >> {head_off, 3'b000};

  always_comb begin
    ld_ext = ld_shift;
    case (head_entry.mtype[1:0])
      2'd0: if (!head_entry.mtype[2]) ld_ext = XPR_LEN'($signed(ld_shift[7:0]));
            else                      ld_ext = XPR_LEN'(ld_shift[7:0]);
      2'd1: if (!head_entry.mtype[2]) ld_ext = XPR_LEN'($signed(ld_shift[15:0]));
            else                      ld_ext = XPR_LEN'(ld_shift[15:0]);
      2'd2: if (!head_entry.mtype[2]) ld_ext = XPR_LEN'($signed(ld_shift[31:0]));
            else                      ld_ext = XPR_LEN'(ld_shift[31:0]);
      default: ld_ext = ld_shift;
    endcase
  end

  always_comb begin
    resp_valid_d = 1'b0;
    resp_wen_d   = 1'b0;
    resp_rd_d    = '0;
    resp_data_d  = '0;
    exc_valid_d  = 1'b0;
    exc_code_d   = '0;
    exc_addr_d   = '0;
    proto_err_d  = proto_err_q | resp_stray;
    if (accept_local) begin
      resp_valid_d = 1'b1;
      resp_wen_d   = req_wen;
      resp_rd_d    = req_wen ? '0 : req_rd;
      exc_valid_d  = 1'b1;
      exc_code_d   = req_wen ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
      exc_addr_d   = req_addr;
    // A response arriving in the flush cycle belongs to a flushed entry as well.
    end else if (resp_hit && !head_drop && !flush) begin
      resp_valid_d = 1'b1;
      resp_wen_d   = head_entry.wen;
      resp_rd_d    = head_entry.wen ? '0 : head_rd;
      if (dmem_resp_err) begin
        exc_valid_d = 1'b1;
        exc_code_d  = head_entry.wen ? EXC_ST_FAULT : EXC_LD_FAULT;
        exc_addr_d  = head_addr;
      end else if (!head_entry.wen) begin
        resp_data_d = ld_ext;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      resp_wen_q   <= 1'b0;
      resp_rd_q    <= '0;
      resp_data_q  <= '0;
      exc_valid_q  <= 1'b0;
      exc_code_q   <= '0;
      exc_addr_q   <= '0;
      proto_err_q  <= 1'b0;
    end else begin
      resp_valid_q <= resp_valid_d;
      resp_wen_q   <= resp_wen_d;
      resp_rd_q    <= resp_rd_d;
      resp_data_q  <= resp_data_d;
      exc_valid_q  <= exc_valid_d;
      exc_code_q   <= exc_code_d;
      exc_addr_q   <= exc_addr_d;
      proto_err_q  <= proto_err_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_wen   = resp_wen_q;
  assign resp_rd    = resp_rd_q;
  assign resp_data  = resp_data_q;
  assign exc_valid  = exc_valid_q;
  assign exc_code   = exc_code_q;
  assign exc_addr   = exc_addr_q;
  assign proto_err  = proto_err_q;

endmodule

// File: tb/tb_vscale_lsu.sv
module tb_vscale_lsu;

  logic        clk, reset_n;
  int unsigned checks = 0;
  int unsigned failures = 0;

  // 32-bit instance, DEPTH=2
  logic        req_valid, req_ready, req_wen, flush;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        dmem_req_valid, dmem_req_ready, dmem_wen;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_resp_valid, dmem_resp_err;
  logic        resp_valid, resp_wen, exc_valid, proto_err;
  logic [4:0]  resp_rd;
  logic [31:0] resp_data, exc_addr;
  logic [3:0]  exc_code;

  // 64-bit instance
  logic        req_valid_w, req_ready_w, req_wen_w, flush_w;
  logic [2:0]  req_type_w;
  logic [63:0] req_addr_w, req_wdata_w;
  logic [4:0]  req_rd_w;
  logic        dmem_req_valid_w, dmem_req_ready_w, dmem_wen_w;
  logic [63:0] dmem_addr_w, dmem_wdata_w, dmem_rdata_w;
  logic [7:0]  dmem_wstrb_w;
  logic        dmem_resp_valid_w, dmem_resp_err_w;
  logic        resp_valid_w, resp_wen_w, exc_valid_w, proto_err_w;
  logic [4:0]  resp_rd_w;
  logic [63:0] resp_data_w, exc_addr_w;
  logic [3:0]  exc_code_w;

  vscale_lsu #(.XPR_LEN(32), .DEPTH(2), .RD_WIDTH(5)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_type(req_type),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd), .flush(flush),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr),
    .dmem_wen(dmem_wen), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_resp_valid(dmem_resp_valid), .dmem_rdata(dmem_rdata), .dmem_resp_err(dmem_resp_err),
    .resp_valid(resp_valid), .resp_wen(resp_wen), .resp_rd(resp_rd), .resp_data(resp_data),
    .exc_valid(exc_valid), .exc_code(exc_code), .exc_addr(exc_addr), .proto_err(proto_err)
  );

  vscale_lsu #(.XPR_LEN(64), .DEPTH(2), .RD_WIDTH(5)) dut64 (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid_w), .req_ready(req_ready_w), .req_wen(req_wen_w), .req_type(req_type_w),
    .req_addr(req_addr_w), .req_wdata(req_wdata_w), .req_rd(req_rd_w), .flush(flush_w),
    .dmem_req_valid(dmem_req_valid_w), .dmem_req_ready(dmem_req_ready_w), .dmem_addr(dmem_addr_w),
    .dmem_wen(dmem_wen_w), .dmem_wstrb(dmem_wstrb_w), .dmem_wdata(dmem_wdata_w),
    .dmem_resp_valid(dmem_resp_valid_w), .dmem_rdata(dmem_rdata_w), .dmem_resp_err(dmem_resp_err_w),
    .resp_valid(resp_valid_w), .resp_wen(resp_wen_w), .resp_rd(resp_rd_w), .resp_data(resp_data_w),
    .exc_valid(exc_valid_w), .exc_code(exc_code_w), .exc_addr(exc_addr_w), .proto_err(proto_err_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic wen, input logic [2:0] typ, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd);
    req_valid = 1'b1;
    req_wen   = wen;
    req_type  = typ;
    req_addr  = addr;
    req_wdata = wdata;
    req_rd    = rd;
    #1;
  endtask

  task automatic issue(input string tag, input logic wen, input logic [2:0] typ,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd);
    drive(wen, typ, addr, wdata, rd);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data, input logic err);
    dmem_resp_valid = 1'b1;
    dmem_rdata      = data;
    dmem_resp_err   = err;
    tick();
    dmem_resp_valid = 1'b0;
    dmem_resp_err   = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    req_valid = 0; req_wen = 0; req_type = 0; req_addr = 0; req_wdata = 0; req_rd = 0;
    flush = 0; dmem_req_ready = 1; dmem_resp_valid = 0; dmem_rdata = 0; dmem_resp_err = 0;
    req_valid_w = 0; req_wen_w = 0; req_type_w = 0; req_addr_w = 0; req_wdata_w = 0; req_rd_w = 0;
    flush_w = 0; dmem_req_ready_w = 1; dmem_resp_valid_w = 0; dmem_rdata_w = 0; dmem_resp_err_w = 0;

    tick(); tick();
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    check("rst_exc_valid", 64'(exc_valid), 64'd0);
    reset_n = 1'b1;
    tick();

    // LW 0x100, response two cycles after accept
    drive(1'b0, 3'd2, 32'h100, 32'h0, 5'd5);
    check("lw_dmem_valid", 64'(dmem_req_valid), 64'd1);
    check("lw_dmem_addr", 64'(dmem_addr), 64'h100);
    check("lw_dmem_wen", 64'(dmem_wen), 64'd0);
    tick();
    req_valid = 1'b0;
    tick();
    respond(32'hDEADBEEF, 1'b0);
    check("lw_resp_valid", 64'(resp_valid), 64'd1);
    check("lw_resp_data", 64'(resp_data), 64'hDEADBEEF);
    check("lw_resp_rd", 64'(resp_rd), 64'd5);
    check("lw_resp_wen", 64'(resp_wen), 64'd0);
    check("lw_exc_valid", 64'(exc_valid), 64'd0);
    tick();
    check("lw_resp_pulse", 64'(resp_valid), 64'd0);

    // LB / LBU 0x103, top byte 0x80
    issue("lb", 1'b0, 3'd0, 32'h103, 32'h0, 5'd7);
    respond(32'h80FFFFFF, 1'b0);
    check("lb_data", 64'(resp_data), 64'hFFFFFF80);
    check("lb_rd", 64'(resp_rd), 64'd7);
    issue("lbu", 1'b0, 3'd4, 32'h103, 32'h0, 5'd8);
    respond(32'h80FFFFFF, 1'b0);
    check("lbu_data", 64'(resp_data), 64'h00000080);

    // SB 0x103
    drive(1'b1, 3'd0, 32'h103, 32'h000000AB, 5'd0);
    check("sb_wstrb", 64'(dmem_wstrb), 64'b1000);
    check("sb_wdata", 64'(dmem_wdata), 64'hAB000000);
    check("sb_addr", 64'(dmem_addr), 64'h100);
    check("sb_wen", 64'(dmem_wen), 64'd1);
    tick();
    req_valid = 1'b0;
    respond(32'h0, 1'b0);
    check("sb_resp_valid", 64'(resp_valid), 64'd1);
    check("sb_resp_wen", 64'(resp_wen), 64'd1);
    check("sb_resp_data", 64'(resp_data), 64'd0);

    // SH 0x102
    drive(1'b1, 3'd1, 32'h102, 32'h00001234, 5'd0);
    check("sh_wstrb", 64'(dmem_wstrb), 64'b1100);
    check("sh_wdata", 64'(dmem_wdata), 64'h12340000);
    tick();
    req_valid = 1'b0;
    respond(32'h0, 1'b0);
    check("sh_resp_wen", 64'(resp_wen), 64'd1);

    // LH 0x102: upper halfword 0x8001 sign extended
    issue("lh", 1'b0, 3'd1, 32'h102, 32'h0, 5'd9);
    respond(32'h80017777, 1'b0);
    check("lh_data", 64'(resp_data), 64'hFFFF8001);

    // Misaligned LW 0x101 with empty queue
    drive(1'b0, 3'd2, 32'h101, 32'h0, 5'd4);
    check("mis_dmem_valid", 64'(dmem_req_valid), 64'd0);
    check("mis_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    check("mis_resp_valid", 64'(resp_valid), 64'd1);
    check("mis_exc_valid", 64'(exc_valid), 64'd1);
    check("mis_exc_code", 64'(exc_code), 64'd4);
    check("mis_exc_addr", 64'(exc_addr), 64'h101);
    check("mis_resp_data", 64'(resp_data), 64'd0);

    // Misaligned SW 0x102
    drive(1'b1, 3'd2, 32'h102, 32'h55, 5'd0);
    check("mis_st_dmem_valid", 64'(dmem_req_valid), 64'd0);
    tick();
    req_valid = 1'b0;
    check("mis_st_code", 64'(exc_code), 64'd6);
    check("mis_st_resp_wen", 64'(resp_wen), 64'd1);

    // Misaligned request while an access is outstanding is held off
    issue("ld200", 1'b0, 3'd2, 32'h200, 32'h0, 5'd10);
    drive(1'b0, 3'd2, 32'h201, 32'h0, 5'd11);
    check("mis_busy_ready", 64'(req_ready), 64'd0);
    check("mis_busy_dmem", 64'(dmem_req_valid), 64'd0);
    req_valid = 1'b0;
    respond(32'h12345678, 1'b0);
    check("ld200_data", 64'(resp_data), 64'h12345678);
    check("ld200_exc", 64'(exc_valid), 64'd0);

    // Access faults
    issue("ldf", 1'b0, 3'd2, 32'h300, 32'h0, 5'd12);
    respond(32'hFFFFFFFF, 1'b1);
    check("ldf_resp_valid", 64'(resp_valid), 64'd1);
    check("ldf_exc_valid", 64'(exc_valid), 64'd1);
    check("ldf_exc_code", 64'(exc_code), 64'd5);
    check("ldf_exc_addr", 64'(exc_addr), 64'h300);
    check("ldf_resp_data", 64'(resp_data), 64'd0);
    issue("stf", 1'b1, 3'd2, 32'h304, 32'h1, 5'd0);
    respond(32'h0, 1'b1);
    check("stf_exc_code", 64'(exc_code), 64'd7);
    check("stf_exc_addr", 64'(exc_addr), 64'h304);

    // Three back-to-back loads into a two-deep queue
    drive(1'b0, 3'd2, 32'h10, 32'h0, 5'd1);
    tick();
    drive(1'b0, 3'd2, 32'h14, 32'h0, 5'd2);
    check("b2b_second_ready", 64'(req_ready), 64'd1);
    tick();
    drive(1'b0, 3'd2, 32'h18, 32'h0, 5'd3);
    check("b2b_full_ready", 64'(req_ready), 64'd0);
    tick();
    check("b2b_full_ready2", 64'(req_ready), 64'd0);
    dmem_resp_valid = 1'b1;
    dmem_rdata = 32'h11;
    #1;
    check("b2b_no_bypass", 64'(req_ready), 64'd0);
    tick();
    dmem_resp_valid = 1'b0;
    check("b2b_r1_data", 64'(resp_data), 64'h11);
    check("b2b_r1_rd", 64'(resp_rd), 64'd1);
    check("b2b_third_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    respond(32'h22, 1'b0);
    check("b2b_r2_data", 64'(resp_data), 64'h22);
    check("b2b_r2_rd", 64'(resp_rd), 64'd2);
    respond(32'h33, 1'b0);
    check("b2b_r3_data", 64'(resp_data), 64'h33);
    check("b2b_r3_rd", 64'(resp_rd), 64'd3);

    // Flush with two loads in flight
    issue("fl1", 1'b0, 3'd2, 32'h40, 32'h0, 5'd13);
    issue("fl2", 1'b0, 3'd2, 32'h44, 32'h0, 5'd14);
    flush = 1'b1;
    #1;
    check("flush_ready", 64'(req_ready), 64'd0);
    tick();
    flush = 1'b0;
    respond(32'hAAAA, 1'b0);
    check("flush_drop1", 64'(resp_valid), 64'd0);
    respond(32'hBBBB, 1'b0);
    check("flush_drop2", 64'(resp_valid), 64'd0);
    check("flush_no_proto", 64'(proto_err), 64'd0);
    drive(1'b0, 3'd2, 32'h41, 32'h0, 5'd0);
    check("flush_empty_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b0;
    #1;
    respond(32'hCCCC, 1'b0);
    check("stray_proto", 64'(proto_err), 64'd1);
    check("stray_resp_valid", 64'(resp_valid), 64'd0);

    // Reset in the middle of activity
    issue("rs1", 1'b0, 3'd2, 32'h50, 32'h0, 5'd3);
    issue("rs2", 1'b0, 3'd2, 32'h54, 32'h0, 5'd4);
    respond(32'h5555, 1'b0);
    check("rs_resp_valid", 64'(resp_valid), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rs_async_resp", 64'(resp_valid), 64'd0);
    check("rs_async_data", 64'(resp_data), 64'd0);
    check("rs_async_proto", 64'(proto_err), 64'd0);
    check("rs_async_ready", 64'(req_ready), 64'd0);
    #2;
    reset_n = 1'b1;
    tick();
    respond(32'h6666, 1'b0);
    check("rs_late_proto", 64'(proto_err), 64'd1);
    check("rs_late_resp", 64'(resp_valid), 64'd0);

    // 64-bit instance
    req_valid_w = 1'b1; req_wen_w = 1'b0; req_type_w = 3'd3; req_addr_w = 64'h8; req_rd_w = 5'd4;
    #1;
    check("ld64_ready", 64'(req_ready_w), 64'd1);
    check("ld64_dmem_addr", dmem_addr_w, 64'h8);
    tick();
    req_valid_w = 1'b0;
    dmem_resp_valid_w = 1'b1; dmem_rdata_w = 64'h0123456789ABCDEF;
    tick();
    dmem_resp_valid_w = 1'b0;
    check("ld64_data", resp_data_w, 64'h0123456789ABCDEF);
    check("ld64_rd", 64'(resp_rd_w), 64'd4);

    req_valid_w = 1'b1; req_type_w = 3'd2; req_addr_w = 64'hC; req_rd_w = 5'd6;
    #1;
    check("lw64_dmem_addr", dmem_addr_w, 64'h8);
    tick();
    req_valid_w = 1'b0;
    dmem_resp_valid_w = 1'b1; dmem_rdata_w = 64'h89ABCDEF_00000000;
    tick();
    dmem_resp_valid_w = 1'b0;
    check("lw64_data", resp_data_w, 64'hFFFFFFFF89ABCDEF);

    req_valid_w = 1'b1; req_wen_w = 1'b1; req_type_w = 3'd2; req_addr_w = 64'hC;
    req_wdata_w = 64'h11223344;
    #1;
    check("sw64_wstrb", 64'(dmem_wstrb_w), 64'hF0);
    check("sw64_wdata", dmem_wdata_w, 64'h11223344_00000000);
    tick();
    req_valid_w = 1'b0;
    dmem_resp_valid_w = 1'b1; dmem_rdata_w = 64'h0;
    tick();
    dmem_resp_valid_w = 1'b0;
    check("sw64_resp_wen", 64'(resp_wen_w), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
